// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: run-control (cycle limit / PC breakpoint halt) and show-ahead event trace FIFO.
// Define TRACE_BP_EN to build the PC breakpoint comparator; otherwise bp_en/bp_pc are ignored.
module cpu_trace_monitor #(
  parameter int STATE_W = 5,
  parameter int DATA_W = 16,
  parameter int CYCLE_W = 32,
  parameter int DEPTH = 16,
  parameter logic [STATE_W-1:0] FETCH_CODE = '0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  clear,
  input  logic [STATE_W-1:0]                    state,
  input  logic [DATA_W-1:0]                     pc,
  input  logic [DATA_W-1:0]                     adr,
  input  logic [DATA_W-1:0]                     writedata,
  input  logic                                  memwrite,
  input  logic [CYCLE_W-1:0]                    cycle_limit,
  input  logic                                  bp_en,
  input  logic [DATA_W-1:0]                     bp_pc,
  output logic                                  running,
  output logic                                  halt,
  output logic [CYCLE_W-1:0]                    cycle_count,
  output logic                                  rd_valid,
  input  logic                                  rd_ready,
  output logic [2+CYCLE_W+STATE_W+2*DATA_W-1:0] rd_data,
  output logic [$clog2(DEPTH):0]                fill,
  output logic                                  overflow,
  output logic [7:0]                            drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = 2 + CYCLE_W + STATE_W + 2 * DATA_W;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fsm_t;

  fsm_t fsm;
  logic [STATE_W-1:0] prev_state;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CYCLE_W-1:0] cnt_next;
  logic [1:0] kind;
  logic bp_hit, halt_now, push, pop, full, wr, drop;
  logic [EW-1:0] entry;

`ifdef TRACE_BP_EN
  assign bp_hit = bp_en && state == FETCH_CODE && pc == bp_pc;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_pc};
  assign bp_hit = 1'b0;
`endif

  // cnt_next is the count "shown" by the current RUN cycle; the first RUN cycle shows 1
  assign cnt_next = &cycle_count ? cycle_count : cycle_count + 1'b1;
  assign halt_now = (cycle_limit != '0 && cnt_next == cycle_limit) || bp_hit;
  assign kind = {memwrite, state != prev_state};
  assign push = fsm == RUN && |kind && !clear;
  assign entry = {kind, cnt_next, state, memwrite ? adr : pc, writedata};
  assign rd_valid = fill != '0;
  assign rd_data = rd_valid ? mem[rptr] : '0;
  assign pop = rd_valid && rd_ready;
  assign full = fill == FULL;
  assign wr = push && (!full || pop);
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm <= IDLE;
      running <= 1'b0;
      halt <= 1'b0;
      cycle_count <= '0;
      prev_state <= '0;
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      prev_state <= state;
      if (clear) begin
        fsm <= IDLE;
        running <= 1'b0;
        halt <= 1'b0;
        cycle_count <= '0;
        wptr <= '0;
        rptr <= '0;
        fill <= '0;
        overflow <= 1'b0;
        drop_count <= '0;
      end else begin
        case (fsm)
          IDLE: if (start) begin
            fsm <= RUN;
            running <= 1'b1;
          end
          RUN: begin
            cycle_count <= cnt_next;
            if (halt_now) begin
              fsm <= HALTED;
              running <= 1'b0;
              halt <= 1'b1;
            end
          end
          default: ;
        endcase
        if (wr) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        fill <= fill + (PW+1)'(wr) - (PW+1)'(pop);
        if (drop) overflow <= 1'b1;
        if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      end
    end
  end
endmodule
